// File: rtl/exu_wb_arbiter.sv
// Round-robin arbiter sharing the integer writeback port between the intblock and memblock load pipes,
// with a single registered output stage and ROB-age based flush kill.
module exu_wb_arbiter #(
   parameter int PREG_W   = 6,
   parameter int RESULT_W = 64,
   parameter int ROB_LOG  = 6
) (
   input  logic                clock,
   input  logic                reset_n,

   input  logic                req0_valid,
   output logic                req0_ready,
   input  logic                req0_need_wb,
   input  logic [PREG_W-1:0]   req0_prd,
   input  logic [RESULT_W-1:0] req0_result,
   input  logic [ROB_LOG:0]    req0_robid,

   input  logic                req1_valid,
   output logic                req1_ready,
   input  logic                req1_need_wb,
   input  logic [PREG_W-1:0]   req1_prd,
   input  logic [RESULT_W-1:0] req1_result,
   input  logic [ROB_LOG:0]    req1_robid,

   input  logic                flush_valid,
   input  logic [ROB_LOG:0]    flush_robid,

   output logic                wb_valid,
   input  logic                wb_ready,
   output logic                wb_need_wb,
   output logic [PREG_W-1:0]   wb_prd,
   output logic [RESULT_W-1:0] wb_result,
   output logic [ROB_LOG:0]    wb_robid,
   output logic                wb_src,
   output logic [31:0]         conflict_cnt
);

   // a is younger than b; the wrap flag inverts the index comparison
   function automatic logic younger(input logic [ROB_LOG:0] a, input logic [ROB_LOG:0] b);
      return (a[ROB_LOG] != b[ROB_LOG]) ^ (a[ROB_LOG-1:0] > b[ROB_LOG-1:0]);
   endfunction

   logic                rr_last_reg;
   logic [1:0]          req_valid;
   logic [1:0]          grant;
   logic [1:0]          req_ready;
   logic                accept;
   logic                sel;
   logic                xfer;
   logic                kill_req;
   logic                held_kill;
   logic                load;
   logic                conflict;
   logic                sel_need_wb;
   logic [PREG_W-1:0]   sel_prd;
   logic [RESULT_W-1:0] sel_result;
   logic [ROB_LOG:0]    sel_robid;

   assign req_valid = {req1_valid, req0_valid};
   assign accept    = !wb_valid || wb_ready;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_req
         localparam logic ME = 1'(gi);
         // contested cycles go to whichever requester did not win last
         assign grant[gi]     = req_valid[gi] && (!req_valid[1-gi] || (rr_last_reg != ME));
         assign req_ready[gi] = accept && grant[gi];
      end
   endgenerate

   assign req0_ready = req_ready[0];
   assign req1_ready = req_ready[1];

   assign sel         = grant[1];
   assign sel_need_wb = sel ? req1_need_wb : req0_need_wb;
   assign sel_prd     = sel ? req1_prd     : req0_prd;
   assign sel_result  = sel ? req1_result  : req0_result;
   assign sel_robid   = sel ? req1_robid   : req0_robid;

   assign xfer      = |req_ready;
   assign kill_req  = flush_valid && younger(sel_robid, flush_robid);
   assign held_kill = flush_valid && wb_valid && younger(wb_robid, flush_robid);
   assign load      = xfer && !kill_req;
   assign conflict  = |(req_valid & ~req_ready);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wb_valid     <= 1'b0;
         wb_need_wb   <= 1'b0;
         wb_prd       <= '0;
         wb_result    <= '0;
         wb_robid     <= '0;
         wb_src       <= 1'b0;
         conflict_cnt <= '0;
         rr_last_reg  <= 1'b1;
      end else begin
         if (load) begin
            wb_valid   <= 1'b1;
            wb_need_wb <= sel_need_wb;
            wb_prd     <= sel_prd;
            wb_result  <= sel_result;
            wb_robid   <= sel_robid;
            wb_src     <= sel;
         end else begin
            // a killed-but-consumed request only happens when the slot was free or draining
            wb_valid <= wb_valid && !wb_ready && !held_kill;
         end
         if (xfer)
            rr_last_reg <= sel;
         if (conflict && (conflict_cnt != 32'hFFFF_FFFF))
            conflict_cnt <= conflict_cnt + 32'd1;
      end
   end

endmodule

// File: tb/tb_exu_wb_arbiter.sv
// Bench for exu_wb_arbiter: reset, single request, contention, then a vector table with flush/wrap cases
// and an asynchronous mid-transfer reset.
module tb_exu_wb_arbiter;

   logic        clock;
   logic        reset_n;
   logic        req0_valid, req0_ready, req0_need_wb;
   logic [5:0]  req0_prd;
   logic [63:0] req0_result;
   logic [6:0]  req0_robid;
   logic        req1_valid, req1_ready, req1_need_wb;
   logic [5:0]  req1_prd;
   logic [63:0] req1_result;
   logic [6:0]  req1_robid;
   logic        flush_valid;
   logic [6:0]  flush_robid;
   logic        wb_valid, wb_ready, wb_need_wb, wb_src;
   logic [5:0]  wb_prd;
   logic [63:0] wb_result;
   logic [6:0]  wb_robid;
   logic [31:0] conflict_cnt;

   int total = 0;
   int bad   = 0;

   exu_wb_arbiter #(.PREG_W(6), .RESULT_W(64), .ROB_LOG(6)) dut (
      .clock(clock), .reset_n(reset_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_need_wb(req0_need_wb),
      .req0_prd(req0_prd), .req0_result(req0_result), .req0_robid(req0_robid),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_need_wb(req1_need_wb),
      .req1_prd(req1_prd), .req1_result(req1_result), .req1_robid(req1_robid),
      .flush_valid(flush_valid), .flush_robid(flush_robid),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_need_wb(wb_need_wb),
      .wb_prd(wb_prd), .wb_result(wb_result), .wb_robid(wb_robid),
      .wb_src(wb_src), .conflict_cnt(conflict_cnt)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   typedef struct {
      logic       r0v;
      logic [6:0] r0id;
      logic       r1v;
      logic [6:0] r1id;
      logic       fv;
      logic [6:0] fid;
      logic       wrdy;
      logic       e0;
      logic       e1;
      logic       ewv;
      logic       esrc;
      logic [6:0] eid;
      int         ecnt;
   } vec_t;

   typedef struct {
      logic       wv;
      logic       src;
      logic [6:0] id;
      int         cnt;
   } exp_t;

   vec_t vecs[18];
   exp_t sb[$];

   function automatic vec_t mk(input logic r0v, input logic [6:0] r0id, input logic r1v,
                               input logic [6:0] r1id, input logic fv, input logic [6:0] fid,
                               input logic wrdy, input logic e0, input logic e1, input logic ewv,
                               input logic esrc, input logic [6:0] eid, input int ecnt);
      vec_t v;
      v.r0v = r0v; v.r0id = r0id; v.r1v = r1v; v.r1id = r1id;
      v.fv = fv; v.fid = fid; v.wrdy = wrdy;
      v.e0 = e0; v.e1 = e1; v.ewv = ewv; v.esrc = esrc; v.eid = eid; v.ecnt = ecnt;
      return v;
   endfunction

   // payload encoding so a wrong source or stale data shows up in prd/result
   function automatic logic [5:0] prd_of(input logic src, input logic [6:0] id);
      return src ? ~id[5:0] : id[5:0];
   endfunction

   function automatic logic [63:0] res_of(input logic src, input logic [6:0] id);
      return {(src ? 32'hBBBB_0000 : 32'hAAAA_0000), 25'd0, id};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      req0_valid = 0; req0_need_wb = 1; req0_prd = '0; req0_result = '0; req0_robid = '0;
      req1_valid = 0; req1_need_wb = 0; req1_prd = '0; req1_result = '0; req1_robid = '0;
      flush_valid = 0; flush_robid = '0; wb_ready = 1;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset_n = 0;
      repeat (2) @(posedge clock);
      #1 reset_n = 1;
   endtask

   initial begin
      vecs[0]  = mk(1, 7'h03, 0, 7'h00, 0, 7'h00, 1,  1, 0,  1, 0, 7'h03, 0);
      vecs[1]  = mk(1, 7'h04, 1, 7'h05, 0, 7'h00, 1,  0, 1,  1, 1, 7'h05, 1);
      vecs[2]  = mk(1, 7'h04, 1, 7'h06, 0, 7'h00, 1,  1, 0,  1, 0, 7'h04, 2);
      vecs[3]  = mk(1, 7'h07, 1, 7'h06, 0, 7'h00, 1,  0, 1,  1, 1, 7'h06, 3);
      vecs[4]  = mk(1, 7'h07, 1, 7'h08, 0, 7'h00, 1,  1, 0,  1, 0, 7'h07, 4);
      vecs[5]  = mk(0, 7'h00, 1, 7'h09, 0, 7'h00, 0,  0, 0,  1, 0, 7'h07, 5);
      vecs[6]  = mk(0, 7'h00, 0, 7'h00, 0, 7'h00, 0,  0, 0,  1, 0, 7'h07, 5);
      vecs[7]  = mk(0, 7'h00, 1, 7'h09, 0, 7'h00, 1,  0, 1,  1, 1, 7'h09, 5);
      vecs[8]  = mk(1, 7'h05, 0, 7'h00, 0, 7'h00, 1,  1, 0,  1, 0, 7'h05, 5);
      vecs[9]  = mk(1, 7'h03, 0, 7'h00, 1, 7'h03, 1,  1, 0,  1, 0, 7'h03, 5);
      vecs[10] = mk(0, 7'h00, 1, 7'h05, 0, 7'h00, 1,  0, 1,  1, 1, 7'h05, 5);
      vecs[11] = mk(1, 7'h02, 0, 7'h00, 1, 7'h03, 0,  0, 0,  0, 0, 7'h00, 6);
      vecs[12] = mk(1, 7'h40, 0, 7'h00, 1, 7'h3F, 1,  1, 0,  0, 0, 7'h00, 6);
      vecs[13] = mk(0, 7'h00, 1, 7'h3E, 1, 7'h3F, 1,  0, 1,  1, 1, 7'h3E, 6);
      vecs[14] = mk(1, 7'h41, 1, 7'h3D, 1, 7'h3F, 1,  1, 0,  0, 0, 7'h00, 7);
      vecs[15] = mk(0, 7'h00, 1, 7'h3D, 1, 7'h3F, 1,  0, 1,  1, 1, 7'h3D, 7);
      vecs[16] = mk(0, 7'h00, 0, 7'h00, 1, 7'h3F, 0,  0, 0,  1, 1, 7'h3D, 7);
      vecs[17] = mk(0, 7'h00, 0, 7'h00, 0, 7'h00, 1,  0, 0,  0, 0, 7'h00, 7);

      do_reset();
      chk("reset_wb_valid", 64'(wb_valid), 64'd0);
      chk("reset_wb_prd", 64'(wb_prd), 64'd0);
      chk("reset_wb_result", wb_result, 64'd0);
      chk("reset_wb_robid", 64'(wb_robid), 64'd0);
      chk("reset_wb_src", 64'(wb_src), 64'd0);
      chk("reset_conflict_cnt", 64'(conflict_cnt), 64'd0);
      $display("reset: wb_valid=%0d conflict_cnt=%0d", wb_valid, conflict_cnt);

      // single request, one-cycle latency
      req0_valid = 1; req0_prd = 6'd5; req0_result = 64'hDEAD; req0_robid = 7'd3;
      @(negedge clock);
      chk("single_req0_ready", 64'(req0_ready), 64'd1);
      @(posedge clock); #1;
      req0_valid = 0;
      chk("single_wb_valid", 64'(wb_valid), 64'd1);
      chk("single_wb_prd", 64'(wb_prd), 64'd5);
      chk("single_wb_result", wb_result, 64'hDEAD);
      chk("single_wb_robid", 64'(wb_robid), 64'd3);
      chk("single_wb_src", 64'(wb_src), 64'd0);
      $display("single: wb_prd=%0d wb_result=%0h wb_src=%0d", wb_prd, wb_result, wb_src);

      // contention straight out of reset: req0 wins first
      do_reset();
      req0_valid = 1; req0_robid = 7'h10; req0_prd = prd_of(0, 7'h10); req0_result = res_of(0, 7'h10);
      req1_valid = 1; req1_robid = 7'h11; req1_prd = prd_of(1, 7'h11); req1_result = res_of(1, 7'h11);
      for (int k = 0; k < 4; k++) begin
         @(negedge clock);
         chk("contend_req0_ready", 64'(req0_ready), 64'(k % 2 == 0));
         chk("contend_req1_ready", 64'(req1_ready), 64'(k % 2 == 1));
         @(posedge clock); #1;
         chk("contend_wb_src", 64'(wb_src), 64'(k % 2));
         $display("contend %0d: wb_src=%0d conflict_cnt=%0d", k, wb_src, conflict_cnt);
      end
      idle_inputs();
      chk("contend_conflict_cnt", 64'(conflict_cnt), 64'd4);

      // vector table, scoreboarded against the registered output stage
      do_reset();
      for (int i = 0; i < 18; i++) begin
         exp_t e;
         req0_valid = vecs[i].r0v; req0_robid = vecs[i].r0id;
         req0_prd = prd_of(0, vecs[i].r0id); req0_result = res_of(0, vecs[i].r0id);
         req1_valid = vecs[i].r1v; req1_robid = vecs[i].r1id;
         req1_prd = prd_of(1, vecs[i].r1id); req1_result = res_of(1, vecs[i].r1id);
         flush_valid = vecs[i].fv; flush_robid = vecs[i].fid; wb_ready = vecs[i].wrdy;
         e.wv = vecs[i].ewv; e.src = vecs[i].esrc; e.id = vecs[i].eid; e.cnt = vecs[i].ecnt;
         sb.push_back(e);
         @(negedge clock);
         chk($sformatf("v%0d_req0_ready", i), 64'(req0_ready), 64'(vecs[i].e0));
         chk($sformatf("v%0d_req1_ready", i), 64'(req1_ready), 64'(vecs[i].e1));
         @(posedge clock); #1;
         e = sb.pop_front();
         chk($sformatf("v%0d_wb_valid", i), 64'(wb_valid), 64'(e.wv));
         chk($sformatf("v%0d_conflict_cnt", i), 64'(conflict_cnt), 64'(e.cnt));
         if (e.wv) begin
            chk($sformatf("v%0d_wb_src", i), 64'(wb_src), 64'(e.src));
            chk($sformatf("v%0d_wb_robid", i), 64'(wb_robid), 64'(e.id));
            chk($sformatf("v%0d_wb_prd", i), 64'(wb_prd), 64'(prd_of(e.src, e.id)));
            chk($sformatf("v%0d_wb_result", i), wb_result, res_of(e.src, e.id));
         end
         $display("vec %0d: rdy=%0d%0d wb_valid=%0d src=%0d robid=%0h cnt=%0d",
                  i, req1_ready, req0_ready, wb_valid, wb_src, wb_robid, conflict_cnt);
      end

      // asynchronous reset while an entry is held under backpressure
      idle_inputs();
      req0_valid = 1; req0_robid = 7'h09; req0_prd = prd_of(0, 7'h09); req0_result = res_of(0, 7'h09);
      wb_ready = 0;
      @(posedge clock); #1;
      req0_valid = 0;
      chk("midreset_held_valid", 64'(wb_valid), 64'd1);
      #2 reset_n = 0;
      #1;
      chk("midreset_wb_valid", 64'(wb_valid), 64'd0);
      chk("midreset_conflict_cnt", 64'(conflict_cnt), 64'd0);
      chk("midreset_wb_robid", 64'(wb_robid), 64'd0);
      $display("midreset: wb_valid=%0d conflict_cnt=%0d", wb_valid, conflict_cnt);
      @(posedge clock); #1 reset_n = 1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
